// File: rtl/risc_cycle_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer sharing one memory port; ALU op 4 cycles, load/store 5.
// Stalls in FETCH/MEM until mem_ready; faults after MEM_TIMEOUT wait cycles; ir_load/mdr_load are Mealy on mem_ready.
module risc_cycle_sequencer #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop_req,
  input  logic             dec_mem_read,
  input  logic             dec_mem_write,
  input  logic             dec_reg_write,
  input  logic             dec_halt,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             mem_addr_sel,
  output logic             ir_load,
  output logic             mdr_load,
  output logic             pc_update,
  output logic             rf_we_en,
  output logic             busy,
  output logic             halted,
  output logic             fault,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT, S_FAULT
  } state_t;

  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  state_t     state;
  state_t     state_nxt;
  logic [7:0] wait_cnt;
  logic       st_q;
  logic       ld_q;
  logic       rw_q;
  logic       st_nxt;
  logic       rw_nxt;
  logic       in_xfer;
  logic       timeout;

  assign in_xfer = (state == S_FETCH) || (state == S_MEM);
  assign timeout = (wait_cnt == WAIT_LAST) && !mem_ready;

  // Access type is captured in EXEC; a simultaneous read+write is a store.
  assign st_nxt = (state == S_EXEC) ? dec_mem_write : st_q;
  assign rw_nxt = (state == S_EXEC) ? dec_reg_write : rw_q;

  assign ir_load  = (state == S_FETCH) && mem_ready && !rst;
  assign mdr_load = (state == S_MEM) && mem_ready && ld_q && !rst;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (start) state_nxt = S_FETCH;
      S_FETCH:  if (mem_ready) state_nxt = S_DECODE;
                else if (timeout) state_nxt = S_FAULT;
      S_DECODE: state_nxt = S_EXEC;
      S_EXEC:   if (dec_halt) state_nxt = S_HALT;
                else if (dec_mem_read || dec_mem_write) state_nxt = S_MEM;
                else state_nxt = S_WB;
      S_MEM:    if (mem_ready) state_nxt = S_WB;
                else if (timeout) state_nxt = S_FAULT;
      S_WB:     state_nxt = stop_req ? S_IDLE : S_FETCH;
      default:  state_nxt = state;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      wait_cnt     <= 8'd0;
      retired      <= '0;
      st_q         <= 1'b0;
      ld_q         <= 1'b0;
      rw_q         <= 1'b0;
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr_sel <= 1'b0;
      pc_update    <= 1'b0;
      rf_we_en     <= 1'b0;
      busy         <= 1'b0;
      halted       <= 1'b0;
      fault        <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == S_EXEC) begin
        st_q <= dec_mem_write;
        ld_q <= dec_mem_read && !dec_mem_write;
        rw_q <= dec_reg_write;
      end
      wait_cnt <= (in_xfer && !mem_ready) ? wait_cnt + 8'd1 : 8'd0;
      if (state == S_WB) retired <= retired + CNT_W'(1);
      mem_req      <= (state_nxt == S_FETCH) || (state_nxt == S_MEM);
      mem_we       <= (state_nxt == S_MEM) && st_nxt;
      mem_addr_sel <= (state_nxt == S_MEM);
      pc_update    <= (state_nxt == S_WB);
      rf_we_en     <= (state_nxt == S_WB) && rw_nxt && !st_nxt;
      busy         <= !((state_nxt == S_IDLE) || (state_nxt == S_HALT) || (state_nxt == S_FAULT));
      halted       <= (state_nxt == S_HALT);
      fault        <= (state_nxt == S_FAULT);
    end
  end

endmodule

// File: doc/risc_cycle_sequencer.md
Name: risc_cycle_sequencer

Overview:
- Multi-cycle control sequencer for the KGP RISC datapath.
- Lets instruction fetch and load/store share one single-port memory with variable latency.
- Steps each instruction through FETCH, DECODE, EXEC, MEM and WB, and gates the PC, IR, MDR and register-file write enables.
- Sits between the main control decoder and the datapath/memory. Detects memory timeouts and halts.

Parameters:
- MEM_TIMEOUT, 16: maximum wait cycles for mem_ready before a fault; legal range 2..255.
- CNT_W, 32: width of the retired-instruction counter.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin execution; honoured only in IDLE.
- stop_req  in  1  request return to IDLE after the current instruction retires.
- dec_mem_read  in  1  decoded load flag for the instruction in IR.
- dec_mem_write  in  1  decoded store flag.
- dec_reg_write  in  1  decoded: instruction writes the register file.
- dec_halt  in  1  decoded halt opcode.
- mem_ready  in  1  memory completes the transfer this cycle.
- mem_req  out  1  memory request.
- mem_we  out  1  write strobe, valid while mem_req=1.
- mem_addr_sel  out  1  address source: 0=PC, 1=ALU result.
- ir_load  out  1  latch instruction register.
- mdr_load  out  1  latch memory data register.
- pc_update  out  1  PC takes its next value.
- rf_we_en  out  1  register-file write enable, ANDed in the datapath.
- busy  out  1  state is not IDLE, HALT or FAULT.
- halted  out  1  state is HALT.
- fault  out  1  state is FAULT.
- retired  out  CNT_W  count of completed instructions.

Behaviour:

Clocking and reset:
- All state updates on the rising edge of clk.
- rst has priority over every other input.
- rst clears the state to IDLE, the wait counter to 0 and retired to 0.
- Every output is 0 on the cycle after rst, including when rst lands mid-transfer: mem_req drops, and no ir_load or pc_update is issued.

States (one-hot or binary, implementer's choice): IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT, FAULT.

Transitions and outputs per state:
- IDLE: all strobes 0. start=1 -> FETCH.
- FETCH: mem_req=1, mem_addr_sel=0, mem_we=0.
  - mem_ready=1: ir_load=1 in the same cycle (Mealy), then -> DECODE.
- DECODE: one cycle for register-file read, no strobes, then -> EXEC.
- EXEC: one ALU cycle. The dec_* inputs are sampled here; IR is stable since DECODE.
  - Priority: dec_halt -> HALT; else (dec_mem_read | dec_mem_write) -> MEM; else -> WB.
  - If both dec_mem_read and dec_mem_write are set, the access is treated as a store.
- MEM: mem_req=1, mem_addr_sel=1, mem_we=dec_mem_write (registered in EXEC).
  - mem_ready=1: mdr_load=1 when the access is a load, then -> WB.
- WB: rf_we_en=dec_reg_write (registered in EXEC; forced 0 for stores), pc_update=1, retired increments.
  - Then stop_req=1 -> IDLE; else -> FETCH.
- HALT: PC not updated, halt instruction not counted. Stays in HALT until rst; start is ignored.
- FAULT: entered on timeout. Stays in FAULT until rst.

Memory handshake:
- A transfer completes on the edge where mem_req=1 and mem_ready=1.
- mem_req, mem_we and mem_addr_sel stay constant until completion.
- mem_ready is ignored while mem_req=0.
- Back-to-back requests (MEM end -> WB -> FETCH) always have at least one cycle with mem_req=0 between them.

Timeout:
- The wait counter clears on entry to FETCH or MEM and increments each cycle mem_req=1 and mem_ready=0.
- When the counter reaches MEM_TIMEOUT-1 with mem_ready=0 -> FAULT. mem_ready=1 on that same cycle wins and the transfer completes normally.

Latency (zero wait states): ALU/branch instruction 4 cycles; load or store 5 cycles. Each memory wait cycle adds 1.

Other rules:
- start while not in IDLE: ignored.
- stop_req outside WB has no effect unless it is still high in WB.
- retired wraps modulo 2^CNT_W.

Test Plan:
- rst, start pulse, 3 ALU instructions, mem_ready tied 1 -> ir_load at cycles 1, 5, 9 after start; pc_update at cycles 4, 8, 12; retired=3; mem_req never high in EXEC.
- Load with 2 fetch and 3 data wait states -> ir_load 3 cycles after entering FETCH, mdr_load 4 cycles after entering MEM; rf_we_en=1 in WB; instruction total 10 cycles.
- Store, dec_reg_write=1 -> mem_we=1 only in MEM, rf_we_en=0 in WB, retired increments.
- mem_ready held 0 with MEM_TIMEOUT=16 -> fault=1 exactly 16 cycles after FETCH entry. Repeat with mem_ready=1 on the 16th cycle -> no fault, DECODE follows.
- dec_halt in EXEC -> halted=1 next cycle, pc_update never pulses, retired unchanged; start ignored; rst -> IDLE with retired=0.
- stop_req=1 during WB -> IDLE, busy=0. rst asserted mid-MEM with mem_ready=1 the same cycle -> next cycle mem_req=0, no mdr_load or pc_update, retired=0.
